req_err_checker: RTL

- Compares a received readout-request reply stream word-by-word against an expected stream supplied in lockstep by the pattern generator.
- The reply sequence is EVT, HDR1, HDR2, N DATA words, then TAG.
- On the first mismatch, latches the expected and received words into per-field registers and raises a 3-bit error code. These registers and the code feed the downstream error-select switch that drives the debug/register interface.
- Also maintains packet and error counters.

---
 rtl/req_err_checker.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/req_err_checker.sv
// req_err_checker: compares a reply stream against its expected stream and latches the first error. Define REQ_ERR_MASK_EN to add the per-beat cmp_mask input.
// Outputs update one cycle after the offending beat; there is no backpressure, and every word_valid beat is consumed.
module req_err_checker #(
   parameter int CNT_W = 16,
   parameter int PKT_W = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [LEN_W-1:0] num_data,
   input  logic             word_valid,
   input  logic             word_first,
   input  logic             word_last,
   input  logic [63:0]      word_in,
   input  logic [63:0]      expc_in,
`ifdef REQ_ERR_MASK_EN
   input  logic [63:0]      cmp_mask,
`endif
   output logic [2:0]       err_en,
   output logic [63:0]      evt_expc,
   output logic [63:0]      evt_seen,
   output logic [63:0]      hdr1_expc,
   output logic [63:0]      hdr1_seen,
   output logic [63:0]      hdr2_expc,
   output logic [63:0]      hdr2_seen,
   output logic [63:0]      data_expc,
   output logic [63:0]      data_seen,
   output logic [63:0]      tag_expc,
   output logic [63:0]      tag_seen,
   output logic             err_valid,
   output logic [CNT_W-1:0] err_cnt,
   output logic [PKT_W-1:0] pkt_cnt,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR1 = 3'd1,
      S_HDR2 = 3'd2,
      S_DATA = 3'd3,
      S_TAG  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] data_left, data_left_nxt;
   logic             mismatch;
   logic             framing;
   logic             pkt_end;
   logic             restart;
   logic             beat_err;
   logic             latch;
   logic             pkt_err;
   logic [2:0]       field_code;

`ifdef REQ_ERR_MASK_EN
   assign mismatch = word_valid && (((word_in ^ expc_in) & cmp_mask) != 64'd0);
`else
   assign mismatch = word_valid && (word_in != expc_in);
`endif

   always_comb begin
      state_nxt     = state;
      data_left_nxt = data_left;
      framing       = 1'b0;
      pkt_end       = 1'b0;
      restart       = 1'b0;
      field_code    = 3'd1;

      // Field/code selection follows the state the word arrived in, framing or not.
      unique case (state)
         S_IDLE:  field_code = 3'd1;
         S_HDR1:  field_code = 3'd2;
         S_HDR2:  field_code = 3'd3;
         S_DATA:  field_code = 3'd4;
         S_TAG:   field_code = 3'd5;
         default: field_code = 3'd1;
      endcase

      if (word_valid) begin
         framing = ((state == S_IDLE) ? !word_first : word_first) ||
                   ((state == S_TAG)  ? !word_last  : word_last);
         if (framing) begin
            pkt_end   = 1'b1;
            state_nxt = S_IDLE;
            restart   = word_first;
         end else begin
            unique case (state)
               S_IDLE: restart = 1'b1;
               S_HDR1: state_nxt = S_HDR2;
               S_HDR2: state_nxt = (data_left == '0) ? S_TAG : S_DATA;
               S_DATA: begin
                  data_left_nxt = data_left - LEN_W'(1);
                  if (data_left == LEN_W'(1)) state_nxt = S_TAG;
               end
               S_TAG: begin
                  pkt_end   = 1'b1;
                  state_nxt = S_IDLE;
               end
               default: state_nxt = S_IDLE;
            endcase
         end
         if (restart) begin
            state_nxt     = S_HDR1;
            data_left_nxt = num_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         data_left <= '0;
      end else begin
         state     <= state_nxt;
         data_left <= data_left_nxt;
      end
   end

   assign busy     = (state != S_IDLE);
   assign beat_err = mismatch || framing;
   // A clear in the same cycle frees the latch, so the new error still lands.
   assign latch    = beat_err && (!err_valid || clear);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_en    <= 3'd0;
         err_valid <= 1'b0;
         evt_expc  <= '0;
         evt_seen  <= '0;
         hdr1_expc <= '0;
         hdr1_seen <= '0;
         hdr2_expc <= '0;
         hdr2_seen <= '0;
         data_expc <= '0;
         data_seen <= '0;
         tag_expc  <= '0;
         tag_seen  <= '0;
      end else if (latch || clear) begin
         err_en    <= 3'd0;
         err_valid <= 1'b0;
         evt_expc  <= '0;
         evt_seen  <= '0;
         hdr1_expc <= '0;
         hdr1_seen <= '0;
         hdr2_expc <= '0;
         hdr2_seen <= '0;
         data_expc <= '0;
         data_seen <= '0;
         tag_expc  <= '0;
         tag_seen  <= '0;
         if (latch) begin
            err_valid <= 1'b1;
            err_en    <= framing ? 3'd6 : field_code;
            unique case (field_code)
               3'd1: begin evt_expc  <= expc_in; evt_seen  <= word_in; end
               3'd2: begin hdr1_expc <= expc_in; hdr1_seen <= word_in; end
               3'd3: begin hdr2_expc <= expc_in; hdr2_seen <= word_in; end
               3'd4: begin data_expc <= expc_in; data_seen <= word_in; end
               3'd5: begin tag_expc  <= expc_in; tag_seen  <= word_in; end
               default: ;
            endcase
         end
      end
   end

   // pkt_err tracks the packet in flight; a restart word opens a new packet
   // whose only possible error so far is its own EVT compare.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_err <= 1'b0;
         err_cnt <= '0;
         pkt_cnt <= '0;
      end else begin
         if (pkt_end) begin
            pkt_cnt <= pkt_cnt + PKT_W'(1);
            if ((pkt_err || beat_err) && (err_cnt != {CNT_W{1'b1}}))
               err_cnt <= err_cnt + CNT_W'(1);
         end
         if (restart)
            pkt_err <= mismatch;
         else if (pkt_end)
            pkt_err <= 1'b0;
         else if (beat_err)
            pkt_err <= 1'b1;
      end
   end

endmodule
